// File: rtl/key_matrix_scan_pkg.sv
// Shared constants, state encoding and event format for the key matrix scanner.
// The key index formula matches the LED matrix image layout.
package key_matrix_scan_pkg;

    localparam int KMS_DIM_X = 6;
    localparam int KMS_DIM_Y = 6;
    localparam int KMS_NKEYS = KMS_DIM_X * KMS_DIM_Y;
    localparam int KMS_IDX_W = 6;
    localparam int KMS_EVT_W = KMS_IDX_W + 1;

    localparam logic [1:0] ST_DWELL  = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;

    typedef struct packed {
        logic [KMS_IDX_W-1:0] index;
        logic                 press;
    } kms_evt_t;

    function automatic logic [KMS_IDX_W-1:0] key_index(
        input logic [2:0] r,
        input logic [2:0] c
    );
        return 6'(r) * 6'(KMS_DIM_X) + 6'(c);
    endfunction

endpackage

// File: rtl/key_matrix_scan_fifo.sv
// Small synchronous event FIFO with a valid/ready read side.
// A push while full is taken only when the head is popped in the same cycle.
module event_fifo
    import key_matrix_scan_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  kms_evt_t i_data,
    output logic     o_drop,
    output logic     o_valid,
    input  logic     i_ready,
    output kms_evt_t o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    kms_evt_t    r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = !w_empty && i_ready;
    assign w_wr    = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// 6x6 key matrix scanner: row drive, column sampling, per-key debounce,
// debounced key image and a press/release event stream.
module key_matrix_scan
    import key_matrix_scan_pkg::*;
#(
    parameter int DIM_X      = KMS_DIM_X,
    parameter int DIM_Y      = KMS_DIM_Y,
    parameter int SCAN_DIV   = 4096,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIM_X-1:0]       col_n,
    output logic [DIM_Y-1:0]       row_n,
    output logic [DIM_X*DIM_Y-1:0] keys,
    output logic                   frame,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [KMS_IDX_W-1:0]   evt_index,
    output logic                   evt_press,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int NK    = DIM_X * DIM_Y;
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [DIM_X-1:0]       r_sync1;
    logic [DIM_X-1:0]       r_sync2;
    logic [DIM_X-1:0]       r_sample;
    logic [DIM_X-1:0]       r_mask;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_row;
    logic [2:0]             r_col;
    logic                   r_live;
    logic                   r_frame;
    logic                   r_ovf;
    logic [NK-1:0]          r_keys;
    logic [1:0]             r_dcnt [NK];

    logic [DIM_X-1:0]       w_raw;
    logic [KMS_IDX_W-1:0]   w_emit_idx;
    logic                   w_push;
    logic                   w_drop;
    kms_evt_t               w_evt;
    kms_evt_t               w_head;

    assign w_raw      = ~r_sync2;
    assign w_emit_idx = key_index(r_row, r_col);
    assign w_push     = (r_state == ST_EMIT) && r_mask[r_col];
    assign w_evt      = '{index: w_emit_idx, press: r_keys[w_emit_idx]};

    // Rows stay released until the first clock after reset.
    assign row_n     = r_live ? ~(DIM_Y'(1) << r_row) : '1;
    assign keys      = r_keys;
    assign frame     = r_frame;
    assign ovf       = r_ovf;
    assign evt_index = w_head.index;
    assign evt_press = w_head.press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= col_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_DWELL;
            r_cnt    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_live   <= 1'b0;
            r_frame  <= 1'b0;
            r_sample <= '0;
            r_mask   <= '0;
            r_keys   <= '0;
            for (int k = 0; k < NK; k++) begin
                r_dcnt[k] <= '0;
            end
        end else begin
            r_live  <= 1'b1;
            r_frame <= 1'b0;
            if (r_live) begin
                unique case (r_state)
                    ST_DWELL: begin
                        if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
                            r_cnt    <= '0;
                            r_sample <= w_raw;
                            r_state  <= ST_UPDATE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_UPDATE: begin
                        r_mask <= '0;
                        for (int c = 0; c < DIM_X; c++) begin
                            if (r_sample[c] == r_keys[key_index(r_row, 3'(c))]) begin
                                r_dcnt[key_index(r_row, 3'(c))] <= '0;
                            end else if (r_dcnt[key_index(r_row, 3'(c))]
                                         == 2'(DEBOUNCE - 1)) begin
                                r_keys[key_index(r_row, 3'(c))] <= r_sample[c];
                                r_dcnt[key_index(r_row, 3'(c))] <= '0;
                                r_mask[c] <= 1'b1;
                            end else begin
                                r_dcnt[key_index(r_row, 3'(c))] <=
                                    r_dcnt[key_index(r_row, 3'(c))] + 1'b1;
                            end
                        end
                        r_col   <= '0;
                        r_state <= ST_EMIT;
                    end
                    ST_EMIT: begin
                        if (r_col == 3'(DIM_X - 1)) begin
                            r_col   <= '0;
                            r_state <= ST_DWELL;
                            if (r_row == 3'(DIM_Y - 1)) begin
                                r_row   <= '0;
                                r_frame <= 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                    default: r_state <= ST_DWELL;
                endcase
            end
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_evt),
        .o_drop  (w_drop),
        .o_valid (evt_valid),
        .i_ready (evt_ready),
        .o_data  (w_head)
    );

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan with a behavioural 6x6 switch matrix.
// SCAN_DIV=8: row period 15 cycles, frame period 90 cycles.
module tb_key_matrix_scan;

    logic        clk;
    logic        rst_n;
    logic [5:0]  col_n;
    logic [5:0]  row_n;
    logic [35:0] keys;
    logic        frame;
    logic        evt_valid;
    logic        evt_ready;
    logic [5:0]  evt_index;
    logic        evt_press;
    logic        ovf;
    logic        ovf_clr;

    logic [35:0] tb_keys;
    int          total;
    int          bad;

    key_matrix_scan #(
        .DIM_X      (6),
        .DIM_Y      (6),
        .SCAN_DIV   (8),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .keys      (keys),
        .frame     (frame),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_index (evt_index),
        .evt_press (evt_press),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed switch pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (!row_n[r] && tb_keys[r*6+c]) begin
                    col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tb_keys   = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (row_n !== 6'b111111 || keys !== 36'd0 || frame !== 1'b0 ||
            evt_valid !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: row_n=%b keys=%h frame=%b valid=%b ovf=%b want 111111/0/0/0/0",
                     row_n, keys, frame, evt_valid, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (row_n !== 6'b111110) begin
            bad++;
            $display("FAIL first_row: row_n=%b want 111110", row_n);
        end
    endtask

    task automatic test_idle();
        logic [5:0] exp_row;
        logic       exp_frame;
        int         nframe;
        do_reset();
        nframe = 0;
        for (int i = 1; i <= 272; i++) begin
            step();
            exp_row   = ~(6'd1 << (((i - 1) / 15) % 6));
            exp_frame = (i > 1) && (((i - 1) % 90) == 0);
            if (frame) nframe++;
            total++;
            if (row_n !== exp_row || frame !== exp_frame) begin
                bad++;
                $display("FAIL idle_scan: cyc=%0d row_n=%b frame=%b want %b %b",
                         i, row_n, frame, exp_row, exp_frame);
            end
            total++;
            if (keys !== 36'd0 || evt_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_quiet: cyc=%0d keys=%h valid=%b want 0 0",
                         i, keys, evt_valid);
            end
        end
        total++;
        if (nframe !== 3) begin
            bad++;
            $display("FAIL idle_frames: got %0d want 3", nframe);
        end
    endtask

    task automatic test_press_release();
        int nev;
        int at0;
        int at1;
        int idx0;
        int idx1;
        int pr0;
        int pr1;
        tb_keys   = '0;
        tb_keys[15] = 1'b1;
        evt_ready = 1'b1;
        do_reset();
        nev = 0; at0 = -1; at1 = -1;
        idx0 = -1; idx1 = -1; pr0 = -1; pr1 = -1;
        for (int i = 1; i <= 500; i++) begin
            step();
            if (i == 219 || i == 220) begin
                total++;
                if (keys[15] !== (i == 220)) begin
                    bad++;
                    $display("FAIL press_state: cyc=%0d keys[15]=%b want %b",
                             i, keys[15], (i == 220));
                end
            end
            if (evt_valid) begin
                if (nev == 0) begin
                    at0 = i; idx0 = int'(evt_index); pr0 = int'(evt_press);
                end else if (nev == 1) begin
                    at1 = i; idx1 = int'(evt_index); pr1 = int'(evt_press);
                end
                nev++;
            end
            if (i == 300) tb_keys[15] = 1'b0;
        end
        total++;
        if (nev !== 2) begin
            bad++;
            $display("FAIL press_count: events=%0d want 2", nev);
        end
        total++;
        if (at0 !== 224 || idx0 !== 15 || pr0 !== 1) begin
            bad++;
            $display("FAIL press_event: cyc=%0d idx=%0d press=%0d want 224 15 1",
                     at0, idx0, pr0);
        end
        total++;
        if (at1 !== 494 || idx1 !== 15 || pr1 !== 0) begin
            bad++;
            $display("FAIL release_event: cyc=%0d idx=%0d press=%0d want 494 15 0",
                     at1, idx1, pr1);
        end
        total++;
        if (keys !== 36'd0) begin
            bad++;
            $display("FAIL release_state: keys=%h want 0", keys);
        end
    endtask

    task automatic test_bounce();
        int nerr;
        tb_keys    = '0;
        tb_keys[0] = 1'b1;
        evt_ready  = 1'b1;
        do_reset();
        nerr = 0;
        for (int i = 1; i <= 540; i++) begin
            step();
            if (keys !== 36'd0 || evt_valid !== 1'b0) nerr++;
            if ((i % 90) == 0) tb_keys[0] = ((i / 90) % 2) == 0;
        end
        total++;
        if (nerr !== 0) begin
            bad++;
            $display("FAIL bounce: %0d cycles with keys/event activity, want 0", nerr);
        end
        tb_keys = '0;
    endtask

    task automatic test_row_overflow();
        tb_keys        = '0;
        tb_keys[29:24] = 6'h3f;
        evt_ready      = 1'b0;
        do_reset();
        repeat (250) step();
        total++;
        if (keys[29:24] !== 6'h3f || evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL row4_state: keys=%h valid=%b want 3f 0",
                     keys[29:24], evt_valid);
        end
        step();
        total++;
        if (evt_valid !== 1'b1 || evt_index !== 6'd24 || evt_press !== 1'b1) begin
            bad++;
            $display("FAIL row4_first: valid=%b idx=%0d press=%b want 1 24 1",
                     evt_valid, evt_index, evt_press);
        end
        repeat (3) step();
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early: ovf=%b want 0", ovf);
        end
        step();
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: ovf=%b want 1", ovf);
        end
        repeat (5) step();
        total++;
        if (ovf !== 1'b1 || evt_index !== 6'd24) begin
            bad++;
            $display("FAIL ovf_hold: ovf=%b idx=%0d want 1 24", ovf, evt_index);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clr: ovf=%b want 0", ovf);
        end
        evt_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (evt_valid !== 1'b1 || evt_index !== 6'(24 + j) || evt_press !== 1'b1) begin
                bad++;
                $display("FAIL drain_%0d: valid=%b idx=%0d press=%b want 1 %0d 1",
                         j, evt_valid, evt_index, evt_press, 24 + j);
            end
            step();
        end
        total++;
        if (evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_empty: valid=%b want 0", evt_valid);
        end
        tb_keys = '0;
    endtask

    task automatic test_hold_pop();
        int nerr;
        tb_keys    = '0;
        tb_keys[0] = 1'b1;
        tb_keys[2] = 1'b1;
        evt_ready  = 1'b0;
        do_reset();
        repeat (195) step();
        nerr = 0;
        for (int i = 195; i < 205; i++) begin
            if (evt_valid !== 1'b1 || evt_index !== 6'd0 || evt_press !== 1'b1) nerr++;
            step();
        end
        total++;
        if (nerr !== 0) begin
            bad++;
            $display("FAIL hold_head: %0d unstable cycles, idx=%0d want 0", nerr, evt_index);
        end
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        total++;
        if (evt_valid !== 1'b1 || evt_index !== 6'd2) begin
            bad++;
            $display("FAIL pop_one: valid=%b idx=%0d want 1 2", evt_valid, evt_index);
        end
        repeat (4) step();
        total++;
        if (evt_valid !== 1'b1 || evt_index !== 6'd2 || evt_press !== 1'b1) begin
            bad++;
            $display("FAIL pop_hold: valid=%b idx=%0d press=%b want 1 2 1",
                     evt_valid, evt_index, evt_press);
        end
    endtask

    task automatic test_reset_emit();
        tb_keys      = '0;
        tb_keys[2:0] = 3'b111;
        evt_ready    = 1'b0;
        do_reset();
        repeat (192) step();
        total++;
        if (evt_valid !== 1'b1 || keys[2:0] !== 3'b111) begin
            bad++;
            $display("FAIL pre_reset: valid=%b keys=%b want 1 111", evt_valid, keys[2:0]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (evt_valid !== 1'b0 || keys !== 36'd0 || row_n !== 6'b111111) begin
            bad++;
            $display("FAIL mid_reset: valid=%b keys=%h row_n=%b want 0 0 111111",
                     evt_valid, keys, row_n);
        end
        step();
        total++;
        if (evt_valid !== 1'b0 || keys !== 36'd0 || row_n !== 6'b111111) begin
            bad++;
            $display("FAIL mid_reset_hold: valid=%b keys=%h row_n=%b want 0 0 111111",
                     evt_valid, keys, row_n);
        end
        tb_keys = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (row_n !== 6'b111110) begin
            bad++;
            $display("FAIL restart_row0: row_n=%b want 111110", row_n);
        end
        repeat (15) step();
        total++;
        if (row_n !== 6'b111101 || evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL restart_row1: row_n=%b valid=%b want 111101 0", row_n, evt_valid);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        tb_keys   = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_idle();
        test_press_release();
        test_bounce();
        test_row_overflow();
        test_hold_pop();
        test_reset_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_matrix_scan.md
# key_matrix_scan

Scanner for a 6x6 multiplexed key or switch matrix: the input-side counterpart of the LED matrix driver. It drives one row at a time and samples the column lines. Each key is debounced over several consecutive scans, and the block publishes both a 36-bit debounced key image and a stream of press/release events through a small FIFO. It sits between the board's matrix pins and the application logic, and uses the same bit mapping as the LED image, so key state can be looped straight back to the display.

## Interface
- `DIM_X`, default 6: columns per row.
- `DIM_Y`, default 6: rows.
- `SCAN_DIV`, default 4096: dwell cycles per row. Must be ≥ 8.
- `DEBOUNCE`, default 3: consecutive differing samples needed to flip a key. Range 1..3.
- `FIFO_DEPTH`, default 4: event FIFO entries. Power of two.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `col_n`  in  DIM_X  column sense lines, pulled up externally. 0 means a key in the driven row is closed. Asynchronous to `clk`.
- `row_n`  out  DIM_Y  row drive, one-cold (0 = driven).
- `keys`  out  DIM_X*DIM_Y  debounced state, 1 = pressed. Bit 6r+c is row r, column c.
- `frame`  out  1  one-cycle pulse when row DIM_Y-1 has finished processing.
- `evt_valid`  out  1  FIFO not empty.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_index`  out  6  key index 6r+c of the head event.
- `evt_press`  out  1  1 = press, 0 = release.
- `ovf`  out  1  sticky flag: an event was dropped because the FIFO was full.
- `ovf_clr`  in  1  synchronous clear of `ovf`.

## Operation
- `col_n` passes through a 2-flop synchronizer, then is inverted to a raw pressed vector.
- FSM states:
  - DWELL: `row_n` drives the current row. A counter runs 0..SCAN_DIV-1. At the final count the synchronized columns are latched, then → UPDATE.
  - UPDATE (1 cycle): for each column c, key k = 6r+c:
    - If the sample equals `keys[k]`, `cnt[k]` ← 0.
    - Otherwise `cnt[k]` increments. On reaching DEBOUNCE, `keys[k]` toggles, `cnt[k]` ← 0, and bit c of the flip mask is set.
    - Then → EMIT.
  - EMIT (DIM_X cycles): visits column 0..5, one per cycle. For each set mask bit, push {6r+c, new state} into the FIFO. If the FIFO is full, drop the event and set `ovf`. After column 5, the row advances (wrapping 5→0, with `frame` pulsed on the wrap), then → DWELL.
- Per-key debounce counters are 2 bits wide, 36 total.
- FIFO handshake:
  - Pop on `evt_valid & evt_ready`.
  - Push and pop in the same cycle while full is allowed: the push succeeds and nothing is dropped.
  - The head of the FIFO stays stable while `evt_valid` is high and `evt_ready` is low.
- If `ovf_clr` and a new drop happen in the same cycle, the drop wins and `ovf` stays 1.
- A key only changes state in UPDATE, so `keys` is stable during DWELL.

## Timing
- Reset values:
  - `row_n` = all 1s.
  - `keys`, `cnt`, `frame`, `evt_valid`, `ovf` = 0.
  - FSM in DWELL on row 0, counter 0, FIFO empty.
- The first cycle after `rst_n` deasserts drives row 0 (`row_n` = 6'b111110).
- Row period is SCAN_DIV + 1 + DIM_X cycles. Frame period is DIM_Y times that.
- Columns must be stable from dwell count SCAN_DIV-3 to be captured, because of the synchronizer.
- `keys` updates on the cycle after UPDATE.
- An event for column c reaches `evt_valid` c+2 cycles after UPDATE, when the FIFO was empty.
- Press-to-state latency is DEBOUNCE frames plus the in-frame offset.
- Reset asserted mid-operation: immediate return to the reset values, and pending events are lost.

## Structure
- Shared package holds:
  - DIM constants.
  - Event width (7).
  - FSM state encoding {DWELL, UPDATE, EMIT}.
  - The index formula 6r+c, shared with the LED driver.
- One sub-module: `event_fifo`, a synchronous FIFO with push/pop, full/empty and valid/ready on the read side.

## Test plan
- No keys pressed for 3 frames (SCAN_DIV=8, row period 15, frame 90 cycles):
  - `row_n` cycles 111110→111101→…→011111, 15 cycles each.
  - `frame` pulses every 90 cycles.
  - `keys` = 0 and no events.
- Hold key row 2, column 3 pressed (col_n[3]=0 while row 2 is driven), DEBOUNCE=3:
  - `keys[15]` rises on the 3rd frame.
  - Exactly one event {15, press} appears.
  - Releasing the key gives {15, release} 3 frames later.
- Bounce: key 0 pressed on alternate frames for 6 frames → `keys[0]` stays 0 and no events.
- Six keys in row 4 pressed together → events 24..29 in column order on consecutive cycles. With `evt_ready`=0 and depth 4:
  - Four events are stored.
  - `ovf` = 1.
  - After `ovf_clr`, `ovf` = 0.
- `evt_ready` held low with one event pending → `evt_index`/`evt_press` stay constant. Raising `evt_ready` for one cycle pops exactly one event.
- Assert `rst_n`=0 during EMIT with events queued:
  - Next cycle `evt_valid` = 0, `keys` = 0, `row_n` = all 1s.
  - After release, scanning restarts at row 0.
